resource_spend_ctrl: RTL and testbench

RESOURCE_SPEND_CTRL -- requirements
Module: resource_spend_ctrl

---
 rtl/resource_spend_ctrl.sv | 159 +++++++++++++++
 tb/tb_resource_spend_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resource_spend_ctrl.sv
// Spend controller for three recharging resource pools (energy, tracer, fluid).
// Requests are checked against the selected balance and answered with a grant/deny response.
module resource_spend_ctrl #(
  parameter int RECHARGE_PERIOD = 16,
  parameter int ENERGY_MAX      = 255,
  parameter int TRACER_MAX      = 63,
  parameter int FLUID_MAX       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  input  logic [7:0] req_amount,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_grant,
  output logic [7:0] rsp_balance,
  input  logic       recharge_en,
  output logic [7:0] energy_level,
  output logic [5:0] tracer_level,
  output logic [3:0] fluid_level
);

  localparam logic [7:0] TIMER_LAST = 8'(RECHARGE_PERIOD - 1);
  localparam logic [7:0] E_MAX      = 8'(ENERGY_MAX);
  localparam logic [7:0] T_MAX      = 8'(TRACER_MAX);
  localparam logic [7:0] F_MAX      = 8'(FLUID_MAX);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic [7:0] amount_q, amount_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] energy_q, energy_d;
  logic [5:0] tracer_q, tracer_d;
  logic [3:0] fluid_q, fluid_d;
  logic       rsp_grant_q, rsp_grant_d;
  logic [7:0] rsp_balance_q, rsp_balance_d;

  logic       tick;
  logic [7:0] energy_rc, tracer_rc, fluid_rc;
  logic [7:0] sel_bal, sel_max, debit, final_bal;
  logic       grant;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] m);
    return (v >= m) ? m : v + 8'd1;
  endfunction

  always_comb begin
    tick    = recharge_en && (timer_q == TIMER_LAST);
    timer_d = timer_q;
    if (recharge_en) begin
      timer_d = tick ? 8'd0 : timer_q + 8'd1;
    end
  end

  // Balances every resource would hold after this edge if nothing were debited.
  always_comb begin
    energy_rc = tick ? sat_inc(energy_q, E_MAX) : energy_q;
    tracer_rc = tick ? sat_inc({2'b00, tracer_q}, T_MAX) : {2'b00, tracer_q};
    fluid_rc  = tick ? sat_inc({4'b0000, fluid_q}, F_MAX) : {4'b0000, fluid_q};
  end

  // Grant test always uses the pre-tick balance; a coinciding tick is added after the debit.
  always_comb begin
    sel_bal = 8'd0;
    sel_max = 8'd0;
    case (kind_q)
      2'd0: begin sel_bal = energy_q;           sel_max = E_MAX; end
      2'd1: begin sel_bal = {2'b00, tracer_q};  sel_max = T_MAX; end
      2'd2: begin sel_bal = {4'b0000, fluid_q}; sel_max = F_MAX; end
      default: begin sel_bal = 8'd0; sel_max = 8'd0; end
    endcase
    grant     = (kind_q != 2'd3) && (amount_q <= sel_bal);
    debit     = sel_bal - amount_q;
    final_bal = tick ? sat_inc(debit, sel_max) : debit;
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    amount_d      = amount_q;
    rsp_grant_d   = rsp_grant_q;
    rsp_balance_d = rsp_balance_q;
    energy_d      = energy_rc;
    tracer_d      = tracer_rc[5:0];
    fluid_d       = fluid_rc[3:0];
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          kind_d   = req_kind;
          amount_d = req_amount;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        state_d     = RESP;
        rsp_grant_d = grant;
        if (grant) begin
          rsp_balance_d = final_bal;
          case (kind_q)
            2'd0:    energy_d = final_bal;
            2'd1:    tracer_d = final_bal[5:0];
            2'd2:    fluid_d  = final_bal[3:0];
            default: energy_d = energy_rc;
          endcase
        end else begin
          case (kind_q)
            2'd0:    rsp_balance_d = energy_rc;
            2'd1:    rsp_balance_d = tracer_rc;
            2'd2:    rsp_balance_d = fluid_rc;
            default: rsp_balance_d = 8'd0;
          endcase
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      kind_q        <= 2'd0;
      amount_q      <= 8'd0;
      timer_q       <= 8'd0;
      energy_q      <= E_MAX;
      tracer_q      <= T_MAX[5:0];
      fluid_q       <= F_MAX[3:0];
      rsp_grant_q   <= 1'b0;
      rsp_balance_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      amount_q      <= amount_d;
      timer_q       <= timer_d;
      energy_q      <= energy_d;
      tracer_q      <= tracer_d;
      fluid_q       <= fluid_d;
      rsp_grant_q   <= rsp_grant_d;
      rsp_balance_q <= rsp_balance_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_grant    = rsp_grant_q;
  assign rsp_balance  = rsp_balance_q;
  assign energy_level = energy_q;
  assign tracer_level = tracer_q;
  assign fluid_level  = fluid_q;

endmodule

// File: tb/tb_resource_spend_ctrl.sv
// Bench for resource_spend_ctrl: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level model of the pools.
module tb_resource_spend_ctrl;

  localparam int PERIOD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic [7:0] req_amount;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_grant;
  logic [7:0] rsp_balance;
  logic       recharge_en;
  logic [7:0] energy_level;
  logic [5:0] tracer_level;
  logic [3:0] fluid_level;

  int checks   = 0;
  int failures = 0;
  bit model_ok = 1'b0;

  resource_spend_ctrl #(
    .RECHARGE_PERIOD(PERIOD),
    .ENERGY_MAX(255),
    .TRACER_MAX(63),
    .FLUID_MAX(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_kind(req_kind),
    .req_amount(req_amount),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_grant(rsp_grant),
    .rsp_balance(rsp_balance),
    .recharge_en(recharge_en),
    .energy_level(energy_level),
    .tracer_level(tracer_level),
    .fluid_level(fluid_level)
  );

  always #5 clk = ~clk;

  // Model: phase 0 waiting, 1 deciding, 2 answering; balances as plain integers.
  typedef struct packed {
    int phase;
    int timer;
    int e;
    int t;
    int f;
    int kind;
    int amt;
    int grant;
    int rbal;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, bit rst, bit valid, int kind, int amt,
                                        bit rdy, bit ren);
    model_t n;
    int maxv[3];
    int cur[3];
    int old;
    int nb;
    bit tick;
    n = s;
    maxv[0] = 255; maxv[1] = 63; maxv[2] = 15;
    if (rst) begin
      n.phase = 0; n.timer = 0; n.e = 255; n.t = 63; n.f = 15;
      n.grant = 0; n.rbal = 0;
      return n;
    end
    tick = ren && (s.timer == PERIOD - 1);
    if (ren) n.timer = (s.timer + 1) % PERIOD;
    cur[0] = s.e; cur[1] = s.t; cur[2] = s.f;
    for (int i = 0; i < 3; i++) begin
      if (tick) cur[i] = (cur[i] + 1 > maxv[i]) ? maxv[i] : cur[i] + 1;
    end
    case (s.phase)
      0: if (valid) begin n.kind = kind; n.amt = amt; n.phase = 1; end
      1: begin
        n.phase = 2;
        if (s.kind == 3) begin
          n.grant = 0;
          n.rbal  = 0;
        end else begin
          old = (s.kind == 0) ? s.e : (s.kind == 1) ? s.t : s.f;
          if (s.amt <= old) begin
            nb = old - s.amt + (tick ? 1 : 0);
            if (nb > maxv[s.kind]) nb = maxv[s.kind];
            cur[s.kind] = nb;
            n.grant = 1;
            n.rbal  = nb;
          end else begin
            n.grant = 0;
            n.rbal  = cur[s.kind];
          end
        end
      end
      2: if (rdy) n.phase = 0;
      default: n.phase = 0;
    endcase
    n.e = cur[0]; n.t = cur[1]; n.f = cur[2];
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_step(m, reset, req_valid, int'(req_kind), int'(req_amount), rsp_ready, recharge_en);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("m_req_ready", int'(req_ready), int'(m.phase == 0));
      checkOutput("m_rsp_valid", int'(rsp_valid), int'(m.phase == 2));
      checkOutput("m_energy", int'(energy_level), m.e);
      checkOutput("m_tracer", int'(tracer_level), m.t);
      checkOutput("m_fluid", int'(fluid_level), m.f);
      if (m.phase == 2) begin
        checkOutput("m_rsp_grant", int'(rsp_grant), m.grant);
        checkOutput("m_rsp_balance", int'(rsp_balance), m.rbal);
      end
    end
  end

  task automatic applyStimulus(input bit valid, input int kind, input int amt,
                               input bit rdy, input bit ren);
    req_valid   = valid;
    req_kind    = 2'(kind);
    req_amount  = 8'(amt);
    rsp_ready   = rdy;
    recharge_en = ren;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!req_ready && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("wait_req_ready", int'(req_ready), 1);
  endtask

  // Issues one request with rsp_ready high and returns the response seen two edges later.
  task automatic doSpend(input int kind, input int amt, input bit ren,
                         output int grant, output int bal);
    waitReady();
    applyStimulus(1'b1, kind, amt, 1'b1, ren);
    stepCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, ren);
    checkOutput("lat_check_no_valid", int'(rsp_valid), 0);
    stepCycle();
    checkOutput("lat_resp_valid", int'(rsp_valid), 1);
    grant = int'(rsp_grant);
    bal   = int'(rsp_balance);
    stepCycle();
    checkOutput("after_handshake_valid", int'(rsp_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    int b;
    int g0;
    int b0;
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    model_ok = 1'b1;
    stepCycle();
    reset = 1'b0;
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rst_req_ready", int'(req_ready), 1);
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_energy", int'(energy_level), 255);
    checkOutput("rst_tracer", int'(tracer_level), 63);
    checkOutput("rst_fluid", int'(fluid_level), 15);
    checkOutput("rst_rsp_grant", int'(rsp_grant), 0);
    checkOutput("rst_rsp_balance", int'(rsp_balance), 0);

    $display("[TB] energy spend 100");
    doSpend(0, 100, 1'b0, g, b);
    checkOutput("e100_grant", g, 1);
    checkOutput("e100_balance", b, 155);
    checkOutput("e100_level", int'(energy_level), 155);
    checkOutput("e100_model", m.e, 155);

    $display("[TB] fluid overdraw then exact spend");
    doSpend(2, 16, 1'b0, g, b);
    checkOutput("f16_grant", g, 0);
    checkOutput("f16_balance", b, 15);
    checkOutput("f16_level", int'(fluid_level), 15);
    doSpend(2, 15, 1'b0, g, b);
    checkOutput("f15_grant", g, 1);
    checkOutput("f15_balance", b, 0);
    checkOutput("f15_level", int'(fluid_level), 0);
    checkOutput("f15_model", m.f, 0);

    $display("[TB] reserved kind");
    doSpend(3, 0, 1'b0, g, b);
    checkOutput("k3_grant", g, 0);
    checkOutput("k3_balance", b, 0);
    checkOutput("k3_energy", int'(energy_level), 155);
    checkOutput("k3_tracer", int'(tracer_level), 63);
    checkOutput("k3_fluid", int'(fluid_level), 0);

    $display("[TB] response stall with competing request");
    waitReady();
    applyStimulus(1'b1, 1, 3, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 0, 5, 1'b0, 1'b0);
    stepCycle();
    g0 = int'(rsp_grant);
    b0 = int'(rsp_balance);
    checkOutput("stall_grant", g0, 1);
    checkOutput("stall_balance", b0, 60);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("stall_valid", int'(rsp_valid), 1);
      checkOutput("stall_ready", int'(req_ready), 0);
      checkOutput("stall_grant_hold", int'(rsp_grant), g0);
      checkOutput("stall_balance_hold", int'(rsp_balance), b0);
    end
    applyStimulus(1'b1, 0, 5, 1'b1, 1'b0);
    stepCycle();
    checkOutput("post_hs_valid", int'(rsp_valid), 0);
    checkOutput("post_hs_ready", int'(req_ready), 1);
    checkOutput("post_hs_energy", int'(energy_level), 155);
    stepCycle();
    checkOutput("second_accepted", int'(req_ready), 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("second_valid", int'(rsp_valid), 1);
    checkOutput("second_balance", int'(rsp_balance), 150);
    stepCycle();

    $display("[TB] recharge tick on decision edge");
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    stepCycle();
    reset = 1'b0;
    stepCycle();
    doSpend(1, 53, 1'b0, g, b);
    checkOutput("t53_balance", b, 10);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 1, 10, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    checkOutput("tick_pre_tracer", int'(tracer_level), 10);
    stepCycle();
    checkOutput("tick_valid", int'(rsp_valid), 1);
    checkOutput("tick_grant", int'(rsp_grant), 1);
    checkOutput("tick_balance", int'(rsp_balance), 1);
    checkOutput("tick_tracer", int'(tracer_level), 1);
    checkOutput("tick_energy_sat", int'(energy_level), 255);
    checkOutput("tick_fluid_sat", int'(fluid_level), 15);
    checkOutput("tick_model", m.t, 1);
    for (int i = 0; i < 20; i++) stepCycle();
    checkOutput("recharged_tracer", int'(tracer_level), 6);

    $display("[TB] reset during decision");
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    waitReady();
    applyStimulus(1'b1, 0, 50, 1'b1, 1'b0);
    stepCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    stepCycle();
    reset = 1'b0;
    checkOutput("midrst_energy", int'(energy_level), 255);
    checkOutput("midrst_valid", int'(rsp_valid), 0);
    checkOutput("midrst_ready", int'(req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("midrst_no_valid", int'(rsp_valid), 0);
      checkOutput("midrst_energy_hold", int'(energy_level), 255);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      stepCycle();
    end
    reset = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
